int_sqrt_param: RTL

INT_SQRT_PARAM -- requirements
Module: int_sqrt_param

---
 rtl/int_sqrt_pkg.sv | 19 +
 rtl/int_sqrt_param_if.sv | 26 ++
 rtl/sqrt_step.sv | 32 +++
 rtl/int_sqrt_param.sv | 102 ++++++++++
 4 files changed

// File: rtl/int_sqrt_pkg.sv
// int_sqrt_pkg
// Purpose: shared definitions for the integer square-root block: the control
//          FSM state encoding and the iteration-count helper.
// Ports:   none (package).
package int_sqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Number of RUN cycles: WIDTH/2 root bits resolved STEPS at a time.
    function automatic int unsigned iter_cycles(input int unsigned width,
                                                input int unsigned steps);
        return width / (2 * steps);
    endfunction

endpackage

// File: rtl/int_sqrt_param_if.sv
// int_sqrt_param_if
// Purpose: request/result handshake bundle for int_sqrt_param.
// Signals: stall, start, d, ack         driven by the requester (master)
//          in_ready, quotient, remainder, ready  driven by the core (slave)
interface int_sqrt_param_if #(
    parameter int unsigned WIDTH = 32
);
    logic               stall;
    logic               start;
    logic [WIDTH-1:0]   d;
    logic               ack;
    logic               in_ready;
    logic [WIDTH/2-1:0] quotient;
    logic [WIDTH/2:0]   remainder;
    logic               ready;

    modport master (
        output stall, start, d, ack,
        input  in_ready, quotient, remainder, ready
    );

    modport slave (
        input  stall, start, d, ack,
        output in_ready, quotient, remainder, ready
    );
endinterface

// File: rtl/sqrt_step.sv
// sqrt_step
// Purpose: one restoring square-root digit iteration (combinational).
// Ports:   i_rem  partial remainder in (WIDTH/2+2 bits)
//          i_root partial root in (WIDTH/2 bits)
//          i_pair next two radicand bits, MSB pair first
//          o_rem  partial remainder out
//          o_root partial root out
module sqrt_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH/2+1:0] i_rem,
    input  logic [WIDTH/2-1:0] i_root,
    input  logic [1:0]         i_pair,
    output logic [WIDTH/2+1:0] o_rem,
    output logic [WIDTH/2-1:0] o_root
);
    localparam int unsigned HW = WIDTH / 2;
    localparam int unsigned RW = HW + 2;

    logic [RW-1:0] w_r;
    logic [RW-1:0] w_t;
    logic          w_ge;
    // Partial remainder never exceeds RW-2 bits between iterations.
    logic          w_unused_rem;

    assign w_unused_rem = ^i_rem[RW-1:RW-2];
    assign w_r    = {i_rem[RW-3:0], i_pair};
    assign w_t    = {i_root, 2'b01};
    assign w_ge   = (w_r >= w_t);
    assign o_rem  = w_ge ? (w_r - w_t) : w_r;
    assign o_root = {i_root[HW-2:0], w_ge};
endmodule

// File: rtl/int_sqrt_param.sv
// int_sqrt_param
// Purpose: iterative unsigned integer square root, STEPS root bits per cycle.
// Ports:   clk   rising-edge clock
//          rst_n asynchronous active-low reset
//          bus   slave side of int_sqrt_param_if: stall/start/d/ack in,
//                in_ready/quotient/remainder/ready out
module int_sqrt_param
    import int_sqrt_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned STEPS = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    int_sqrt_param_if.slave   bus
);
    localparam int unsigned HW   = WIDTH / 2;
    localparam int unsigned RW   = HW + 2;
    localparam int unsigned NCYC = iter_cycles(WIDTH, STEPS);
    localparam int unsigned CW   = $clog2(NCYC) + 1;

    state_e           r_state, w_state_d;
    logic [WIDTH-1:0] r_dsh, w_dsh_d;
    logic [HW-1:0]    r_root, w_root_d;
    logic [RW-1:0]    r_rem, w_rem_d;
    logic [CW-1:0]    r_cnt, w_cnt_d;

    logic [RW-1:0]    w_rem_c  [STEPS+1];
    logic [HW-1:0]    w_root_c [STEPS+1];

    assign w_rem_c[0]  = r_rem;
    assign w_root_c[0] = r_root;

    for (genvar s = 0; s < STEPS; s++) begin : g_step
        sqrt_step #(
            .WIDTH (WIDTH)
        ) u_step (
            .i_rem  (w_rem_c[s]),
            .i_root (w_root_c[s]),
            .i_pair (r_dsh[WIDTH-1-2*s -: 2]),
            .o_rem  (w_rem_c[s+1]),
            .o_root (w_root_c[s+1])
        );
    end

    always_comb begin
        w_state_d = r_state;
        w_dsh_d   = r_dsh;
        w_root_d  = r_root;
        w_rem_d   = r_rem;
        w_cnt_d   = r_cnt;
        unique case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_state_d = RUN;
                    w_dsh_d   = bus.d;
                    w_root_d  = '0;
                    w_rem_d   = '0;
                    w_cnt_d   = '0;
                end
            end
            RUN: begin
                w_dsh_d  = r_dsh << (2 * STEPS);
                w_root_d = w_root_c[STEPS];
                w_rem_d  = w_rem_c[STEPS];
                w_cnt_d  = r_cnt + 1'b1;
                if (r_cnt == CW'(NCYC - 1)) begin
                    w_state_d = DONE;
                end
            end
            DONE: begin
                // Leaving DONE lands in IDLE; a new accept needs the next cycle.
                if (bus.ack) begin
                    w_state_d = IDLE;
                end
            end
            default: w_state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_dsh   <= '0;
            r_root  <= '0;
            r_rem   <= '0;
            r_cnt   <= '0;
        end else if (!bus.stall) begin
            r_state <= w_state_d;
            r_dsh   <= w_dsh_d;
            r_root  <= w_root_d;
            r_rem   <= w_rem_d;
            r_cnt   <= w_cnt_d;
        end
    end

    // Outputs decode straight from state so reset clears them without a clock.
    assign bus.in_ready  = (r_state == IDLE);
    assign bus.ready     = (r_state == DONE);
    assign bus.quotient  = (r_state == DONE) ? r_root : '0;
    assign bus.remainder = (r_state == DONE) ? r_rem[HW:0] : '0;
endmodule
